// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default amplitude width, range helpers and the
// capture decoder state encoding; imported by both the generator and the capture block.
package pwm_pkg;

  localparam int XLEN_DEF = 8;

  // Longest measurable period: all-ones in the XLEN+1 bit period field.
  function automatic int pmax(input int xlen);
    return (1 << (xlen + 1)) - 1;
  endfunction

  // Largest representable amplitude: all-ones in the XLEN bit ampl field.
  function automatic int amax(input int xlen);
    return (1 << xlen) - 1;
  endfunction

  typedef enum logic [1:0] {SYNC, HIGH, LOW} cap_state_e;

endpackage

// File: rtl/pwm_in_filter.sv
// Input conditioning: SYNC_STAGES-flop synchronizer, optional deglitch filter
// (PWM_CAPTURE_DEGLITCH_EN, adds DEGLITCH_LEN cycles) and rise/fall detection.
module pwm_in_filter
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEGLITCH_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_s;
  logic                   s_w;
  logic                   s_q, s_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
    s_d    = s_w;
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_q    <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s_q    <= s_d;
    end
  end

`ifdef PWM_CAPTURE_DEGLITCH_EN
  localparam bit DG_EN = 1'b1;
`else
  localparam bit DG_EN = 1'b0;
`endif

  generate
    if (DG_EN && DEGLITCH_LEN >= 1) begin : g_deglitch
      localparam int            CW   = $clog2(DEGLITCH_LEN + 1);
      localparam logic [CW-1:0] LAST = CW'(DEGLITCH_LEN - 1);

      logic [CW-1:0] run_q, run_d;
      logic          filt_q, filt_d;

      // Flip only on the DEGLITCH_LEN-th consecutive differing sample, so
      // both edges see the same delay and pulse widths are preserved.
      always_comb begin
        run_d  = '0;
        filt_d = filt_q;
        if (sync_s != filt_q) begin
          if (run_q == LAST) begin
            filt_d = sync_s;
          end else begin
            run_d = run_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          run_q  <= '0;
          filt_q <= 1'b0;
        end else begin
          run_q  <= run_d;
          filt_q <= filt_d;
        end
      end

      assign s_w = filt_q;
    end else begin : g_raw
      assign s_w = sync_s;
    end
  endgenerate

  assign s    = s_w;
  assign rise = s_w & ~s_q;
  assign fall = ~s_w & s_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period (rise to rise) and high time of pwm_in in clk cycles,
// published one cycle after the closing rise; PWM_CAPTURE_DEGLITCH_EN adds an input glitch filter.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int SYNC_STAGES  = 2,
  parameter int DEGLITCH_LEN = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            pwm_in,
  output logic [XLEN-1:0] ampl,
  output logic [XLEN:0]   period,
  output logic            valid,
  output logic            stuck,
  output logic            stuck_level,
  output logic            sat
);

  localparam int            PW   = XLEN + 1;
  localparam logic [XLEN:0] PMAX = PW'(pmax(XLEN));
  localparam logic [XLEN:0] AMAX = PW'(amax(XLEN));
  localparam logic [XLEN:0] ONE  = PW'(1);

  logic s, rise, fall;

  cap_state_e      state_q, state_d;
  logic [XLEN:0]   pcnt_q, pcnt_d;
  logic [XLEN:0]   hcnt_q, hcnt_d;
  logic [XLEN-1:0] ampl_q, ampl_d;
  logic [XLEN:0]   period_q, period_d;
  logic            valid_q, valid_d;
  logic            stuck_q, stuck_d;
  logic            stuck_level_q, stuck_level_d;
  logic            sat_q, sat_d;
  logic [XLEN:0]   pcnt_inc;
  logic            timeout;

  pwm_in_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEGLITCH_LEN (DEGLITCH_LEN)
  ) u_in_filter (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  always_comb begin
    state_d       = state_q;
    pcnt_d        = pcnt_q;
    hcnt_d        = hcnt_q;
    ampl_d        = ampl_q;
    period_d      = period_q;
    valid_d       = 1'b0;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;
    sat_d         = sat_q;
    pcnt_inc      = (pcnt_q == PMAX) ? PMAX : pcnt_q + 1'b1;
    // In SYNC pcnt doubles as the cycles-since-last-edge counter.
    timeout       = (pcnt_q == PMAX) && !rise && !fall;

    if (!enable) begin
      state_d = SYNC;
      pcnt_d  = '0;
      hcnt_d  = '0;
    end else begin
      if (rise || fall) begin
        stuck_d = 1'b0;
      end
      case (state_q)
        SYNC: begin
          if (rise) begin
            pcnt_d  = ONE;
            hcnt_d  = ONE;
            state_d = HIGH;
          end else if (fall) begin
            pcnt_d = ONE;
          end else begin
            pcnt_d = pcnt_inc;
          end
        end
        HIGH: begin
          if (fall) begin
            // A high phase of PMAX leaves no room for a low phase: resync.
            if (pcnt_q == PMAX) begin
              pcnt_d  = ONE;
              state_d = SYNC;
            end else begin
              pcnt_d  = pcnt_inc;
              state_d = LOW;
            end
          end else begin
            pcnt_d = pcnt_inc;
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            period_d = pcnt_q;
            ampl_d   = (hcnt_q > AMAX) ? AMAX[XLEN-1:0] : hcnt_q[XLEN-1:0];
            sat_d    = (hcnt_q > AMAX);
            valid_d  = 1'b1;
            pcnt_d   = ONE;
            hcnt_d   = ONE;
            state_d  = HIGH;
          end else begin
            pcnt_d = pcnt_inc;
          end
        end
        default: state_d = SYNC;
      endcase
      if (timeout) begin
        stuck_d       = 1'b1;
        stuck_level_d = s;
        state_d       = SYNC;
        pcnt_d        = PMAX;
        hcnt_d        = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SYNC;
      pcnt_q        <= '0;
      hcnt_q        <= '0;
      ampl_q        <= '0;
      period_q      <= '0;
      valid_q       <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
      sat_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      hcnt_q        <= hcnt_d;
      ampl_q        <= ampl_d;
      period_q      <= period_d;
      valid_q       <= valid_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
      sat_q         <= sat_d;
    end
  end

  assign ampl        = ampl_q;
  assign period      = period_q;
  assign valid       = valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: loopback, saturation, stuck input, enable,
// glitch and asynchronous reset, checked against hand-computed values.
module tb_pwm_capture;

  localparam int XLEN   = 8;
  localparam int SETTLE = 8;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic enable = 1'b0;
  logic pwm_in = 1'b0;

  logic [XLEN-1:0] ampl;
  logic [XLEN:0]   period;
  logic            valid;
  logic            stuck;
  logic            stuck_level;
  logic            sat;

  int n_vec    = 0;
  int n_err    = 0;
  int vcnt     = 0;
  int cyc      = 0;
  int last_cyc = 0;
  int last_gap = 0;
  int v0       = 0;

  logic [XLEN-1:0] last_ampl   = '0;
  logic [XLEN:0]   last_period = '0;
  logic            last_sat    = 1'b0;

  pwm_capture #(
    .XLEN         (XLEN),
    .SYNC_STAGES  (2),
    .DEGLITCH_LEN (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pwm_in      (pwm_in),
    .ampl        (ampl),
    .period      (period),
    .valid       (valid),
    .stuck       (stuck),
    .stuck_level (stuck_level),
    .sat         (sat)
  );

  always #5 clk = ~clk;

  // Records each valid pulse just after the edge that produced it.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (valid === 1'b1) begin
      vcnt++;
      last_gap    = cyc - last_cyc;
      last_cyc    = cyc;
      last_ampl   = ampl;
      last_period = period;
      last_sat    = sat;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic gen_period(input int hi, input int lo);
    pwm_in = 1'b1;
    wait_n(hi);
    pwm_in = 1'b0;
    wait_n(lo);
  endtask

  // 6 high / 14 low with a 2-cycle low dropout inside the high phase.
  task automatic glitch_period();
    pwm_in = 1'b1; wait_n(3);
    pwm_in = 1'b0; wait_n(2);
    pwm_in = 1'b1; wait_n(1);
    pwm_in = 1'b0; wait_n(14);
  endtask

  initial begin
    wait_n(4);
    chk("rst_ampl", ampl, 0);
    chk("rst_period", period, 0);
    chk("rst_valid", valid, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_stuck_level", stuck_level, 0);
    chk("rst_sat", sat, 0);

    rst    = 1'b0;
    enable = 1'b1;
    wait_n(4);

    // Loopback of a 3/10 generator setting.
    gen_period(3, 7);
    chk("lb_first_rise_no_valid", vcnt, 0);
    repeat (4) gen_period(3, 7);
    chk("lb_valid_count", vcnt, 4);
    chk("lb_ampl", last_ampl, 3);
    chk("lb_period", last_period, 10);
    chk("lb_sat", last_sat, 0);
    chk("lb_valid_gap", last_gap, 10);

    // High time beyond the ampl range clips to all-ones.
    v0 = vcnt;
    gen_period(300, 100);
    pwm_in = 1'b1;
    wait_n(SETTLE);
    chk("sat_valid_count", vcnt, v0 + 2);
    chk("sat_ampl", last_ampl, 255);
    chk("sat_period", last_period, 400);
    chk("sat_flag_at_valid", last_sat, 1);
    chk("sat_out", sat, 1);

    // Input stuck high: timeout near cycle 511 after the rise.
    v0 = vcnt;
    wait_n(400 - SETTLE);
    chk("stuck_not_yet", stuck, 0);
    wait_n(200);
    chk("stuck_set", stuck, 1);
    chk("stuck_level", stuck_level, 1);
    chk("stuck_no_valid", vcnt, v0);
    chk("stuck_hold_ampl", ampl, 255);
    chk("stuck_hold_period", period, 400);
    pwm_in = 1'b0;
    wait_n(SETTLE);
    chk("stuck_cleared", stuck, 0);
    gen_period(4, 12);
    gen_period(4, 12);
    pwm_in = 1'b1;
    wait_n(SETTLE);
    chk("recover_ampl", ampl, 4);
    chk("recover_period", period, 16);
    chk("recover_sat", sat, 0);

    // Enable dropped mid-HIGH.
    v0 = vcnt;
    enable = 1'b0;
    wait_n(3);
    enable = 1'b1;
    wait_n(5);
    pwm_in = 1'b0;
    wait_n(10);
    chk("en_no_valid", vcnt, v0);
    chk("en_hold_ampl", ampl, 4);
    chk("en_hold_period", period, 16);
    gen_period(6, 9);
    chk("en_one_rise_no_valid", vcnt, v0);
    pwm_in = 1'b1;
    wait_n(SETTLE);
    chk("en_two_rise_valid", vcnt, v0 + 1);
    chk("en_ampl", ampl, 6);
    chk("en_period", period, 15);

    // Low dropout inside the high phase.
    pwm_in = 1'b0;
    wait_n(10);
    v0 = vcnt;
    glitch_period();
    glitch_period();
    pwm_in = 1'b1;
    wait_n(SETTLE);
`ifdef PWM_CAPTURE_DEGLITCH_EN
    chk("glitch_valid_count", vcnt, v0 + 3);
    chk("glitch_ampl", ampl, 6);
    chk("glitch_period", period, 20);
`else
    chk("glitch_valid_count", vcnt, v0 + 5);
    chk("glitch_ampl", ampl, 1);
    chk("glitch_period", period, 15);
`endif

    // Reset mid-LOW clears outputs without a clock edge.
    pwm_in = 1'b0;
    wait_n(5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ampl", ampl, 0);
    chk("arst_period", period, 0);
    chk("arst_valid", valid, 0);
    chk("arst_stuck", stuck, 0);
    chk("arst_stuck_level", stuck_level, 0);
    chk("arst_sat", sat, 0);
    wait_n(3);
    rst = 1'b0;
    wait_n(4);
    v0 = vcnt;
    gen_period(4, 6);
    chk("post_rst_one_rise_no_valid", vcnt, v0);
    pwm_in = 1'b1;
    wait_n(SETTLE);
    chk("post_rst_valid", vcnt, v0 + 1);
    chk("post_rst_ampl", ampl, 4);
    chk("post_rst_period", period, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
